// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared widths and state encodings for the code-entry lock
// Purpose: digit/state width constants and the FSM state encodings used by
//          lock_sequencer and by anything decoding its state output.
// Ports:   none (package).
package lock_pkg;

   localparam int DIGIT_W = 4;
   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_ENTER   = 3'd1;
   localparam logic [STATE_W-1:0] ST_CHECK   = 3'd2;
   localparam logic [STATE_W-1:0] ST_OPEN    = 3'd3;
   localparam logic [STATE_W-1:0] ST_FAIL    = 3'd4;
   localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd5;
   localparam logic [STATE_W-1:0] ST_PROGRAM = 3'd6;

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with terminal count
// Purpose: times the OPEN and LOCKOUT windows; one instance serves both.
// Ports:   clock      - rising-edge clock
//          reset      - synchronous active-low reset (count -> 0)
//          load       - load load_value on this edge
//          load_value - start value (cycles remaining minus one)
//          tc         - terminal count, high while the count is zero
module lock_timer #(
   parameter int MAX_COUNT = 16,
   parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - code-entry lock sequencing FSM
// Purpose: collects keypad digits on confirm rising edges, compares the
//          entry against the stored code, opens the lock for a bounded time,
//          and escalates repeated failures into a timed lockout with alarm.
// Option:  LOCK_PROGRAM_EN - when defined, program_req in OPEN enters PROGRAM
//          and the next CODE_LEN digits replace the code register.
// Ports:   clock       - rising-edge clock
//          reset       - synchronous active-low reset
//          confirm     - digit strobe (level), accepted on its rising edge
//          in          - digit value sampled with the accepted edge
//          program_req - code change request while open
//          state       - current FSM state encoding
//          left        - previously accepted digit
//          right       - most recently accepted digit
//          unlocked    - lock actuator enable
//          alarm       - lockout indicator
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int                          CODE_LEN    = 2,
   parameter logic [DIGIT_W*CODE_LEN-1:0] RESET_CODE  = 8'hFA,
   parameter int                          MAX_FAILS   = 3,
   parameter int                          OPEN_CYCLES = 8,
   parameter int                          LOCK_CYCLES = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               confirm,
   input  logic [DIGIT_W-1:0] in,
   input  logic               program_req,
   output logic [STATE_W-1:0] state,
   output logic [DIGIT_W-1:0] left,
   output logic [DIGIT_W-1:0] right,
   output logic               unlocked,
   output logic               alarm
);

   localparam int BUF_W  = DIGIT_W * CODE_LEN;
   localparam int CNT_W  = 3;
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int TMAX   = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int TMR_W  = $clog2(TMAX + 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic               prev_confirm;
   logic [DIGIT_W-1:0] left_q, right_q;
   logic [BUF_W-1:0]   buffer, buffer_next, code;
   logic [CNT_W-1:0]   count;
   logic [FAIL_W-1:0]  fail_cnt, fail_sat;
   logic               accepting, accept, last_digit, code_match, clear_entry;
   logic               timer_load, timer_tc;
   logic [TMR_W-1:0]   timer_value;

`ifdef LOCK_PROGRAM_EN
   assign accepting = (state_q == ST_IDLE) || (state_q == ST_ENTER) ||
                      (state_q == ST_PROGRAM);
`else
   assign accepting = (state_q == ST_IDLE) || (state_q == ST_ENTER);
`endif

   // Edges arriving in non-accepting states are simply lost.
   assign accept      = confirm && !prev_confirm && accepting;
   assign last_digit  = (count == CNT_W'(CODE_LEN - 1));
   assign buffer_next = (buffer << DIGIT_W) | BUF_W'(in);
   assign code_match  = (buffer == code);
   assign fail_sat    = (fail_cnt >= FAIL_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;

`ifdef LOCK_PROGRAM_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         code <= RESET_CODE;
      end else if (state_q == ST_PROGRAM && accept && last_digit) begin
         code <= buffer_next;
      end
   end
`else
   logic unused_program;
   assign code           = RESET_CODE;
   assign unused_program = program_req;
`endif

   always_comb begin
      state_d     = state_q;
      timer_load  = 1'b0;
      timer_value = '0;
      case (state_q)
         ST_IDLE, ST_ENTER: begin
            if (accept) state_d = last_digit ? ST_CHECK : ST_ENTER;
         end
         ST_CHECK: begin
            if (code_match) begin
               state_d     = ST_OPEN;
               timer_load  = 1'b1;
               timer_value = TMR_W'(OPEN_CYCLES - 1);
            end else begin
               state_d = ST_FAIL;
            end
         end
         ST_FAIL: begin
            if (fail_sat == FAIL_W'(MAX_FAILS)) begin
               state_d     = ST_LOCKOUT;
               timer_load  = 1'b1;
               timer_value = TMR_W'(LOCK_CYCLES - 1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OPEN: begin
`ifdef LOCK_PROGRAM_EN
            // A program request beats a simultaneous timer expiry.
            if (program_req) state_d = ST_PROGRAM;
            else
`endif
            if (timer_tc) state_d = ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (timer_tc) state_d = ST_IDLE;
         end
`ifdef LOCK_PROGRAM_EN
         ST_PROGRAM: begin
            if (accept && last_digit) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Entry into IDLE (and into PROGRAM) starts a fresh digit collection.
`ifdef LOCK_PROGRAM_EN
   assign clear_entry = ((state_d == ST_IDLE) && (state_q != ST_IDLE)) ||
                        ((state_d == ST_PROGRAM) && (state_q != ST_PROGRAM));
`else
   assign clear_entry = (state_d == ST_IDLE) && (state_q != ST_IDLE);
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         prev_confirm <= 1'b1;   // a confirm held through reset is not an edge
         left_q       <= '0;
         right_q      <= '0;
         buffer       <= '0;
         count        <= '0;
         fail_cnt     <= '0;
      end else begin
         state_q      <= state_d;
         prev_confirm <= confirm;
         if (accept) begin
            left_q  <= right_q;
            right_q <= in;
         end
         if (clear_entry) begin
            buffer <= '0;
            count  <= '0;
         end else if (accept) begin
            buffer <= buffer_next;
            count  <= count + 1'b1;
         end
         if (state_q == ST_CHECK && code_match) begin
            fail_cnt <= '0;
         end else if (state_q == ST_FAIL) begin
            fail_cnt <= fail_sat;
         end else if (state_q == ST_LOCKOUT && timer_tc) begin
            fail_cnt <= '0;
         end
      end
   end

   lock_timer #(
      .MAX_COUNT (TMAX),
      .WIDTH     (TMR_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .tc         (timer_tc)
   );

   assign state = state_q;
   assign left  = left_q;
   assign right = right_q;
   assign alarm = (state_q == ST_LOCKOUT);
`ifdef LOCK_PROGRAM_EN
   assign unlocked = (state_q == ST_OPEN) || (state_q == ST_PROGRAM);
`else
   assign unlocked = (state_q == ST_OPEN);
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - scoreboard bench for lock_sequencer
module tb_lock_sequencer;

   localparam logic [7:0] RESET_CODE  = 8'hFA;
   localparam int         MAX_FAILS   = 3;
   localparam int         OPEN_CYCLES = 8;
   localparam int         LOCK_CYCLES = 16;

   localparam logic [2:0] S_IDLE = 3'd0, S_ENTER = 3'd1, S_CHECK = 3'd2, S_OPEN = 3'd3,
                          S_FAIL = 3'd4, S_LOCK  = 3'd5, S_PROG  = 3'd6;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       confirm = 1'b0;
   logic       program_req = 1'b0;
   logic [3:0] digit = 4'h0;
   logic [2:0] state;
   logic [3:0] left, right;
   logic       unlocked, alarm;

   lock_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .confirm     (confirm),
      .in          (digit),
      .program_req (program_req),
      .state       (state),
      .left        (left),
      .right       (right),
      .unlocked    (unlocked),
      .alarm       (alarm)
   );

   always #5 clock = ~clock;

   // One expected stretch of constant state; len 0 means any duration.
   typedef struct {
      logic [2:0] st;
      int         len;
      bit         chk_lr;
      logic [3:0] l;
      logic [3:0] r;
   } seg_t;

   seg_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass = 0;
   bit         mon_en = 1'b0;
   logic [7:0] model_code;
   int         model_fails;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic bit decode_ok();
      return (unlocked === (state == S_OPEN || state == S_PROG)) && (alarm === (state == S_LOCK));
   endfunction

   function automatic void push(input logic [2:0] st, input int len, input bit chk,
                                input logic [3:0] l, input logic [3:0] r);
      seg_t s;
      s.st = st; s.len = len; s.chk_lr = chk; s.l = l; s.r = r;
      exp_q.push_back(s);
   endfunction

   // Monitor: a segment closes whenever state changes; pop and compare.
   bit         seg_active = 1'b0;
   logic [2:0] seg_st;
   int         seg_len;
   bit         seg_ok;

   task automatic close_segment();
      seg_t e;
      if (exp_q.size() == 0) begin
         check($sformatf("unexpected_segment_st%0d", seg_st), 32'(seg_st), 32'hFF);
      end else begin
         e = exp_q.pop_front();
         check("seg_state", 32'(seg_st), 32'(e.st));
         if (e.len != 0) check($sformatf("seg_len_st%0d", e.st), 32'(seg_len), 32'(e.len));
         check($sformatf("seg_outputs_st%0d", e.st), 32'(seg_ok), 32'd1);
         if (e.chk_lr) begin
            check($sformatf("left_after_st%0d", e.st), 32'(left), 32'(e.l));
            check($sformatf("right_after_st%0d", e.st), 32'(right), 32'(e.r));
         end
      end
   endtask

   always @(negedge clock) begin
      if (!mon_en) begin
         seg_active = 1'b0;
      end else if (!seg_active) begin
         seg_active = 1'b1; seg_st = state; seg_len = 1; seg_ok = decode_ok();
      end else if (state == seg_st) begin
         seg_len++;
         if (!decode_ok()) seg_ok = 1'b0;
      end else begin
         close_segment();
         seg_st = state; seg_len = 1; seg_ok = decode_ok();
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] d, input int h, input int l);
      confirm = 1'b1; digit = d;
      repeat (h) tick();
      confirm = 1'b0;
      repeat (l) tick();
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         tick();
         t++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Attempt-level reference: right code opens, otherwise count a failure
   // and lock out on the MAX_FAILS-th consecutive one.
   task automatic attempt(input logic [3:0] d0, input logic [3:0] d1, input bit prog,
                          input logic [3:0] p0, input logic [3:0] p1);
      bit opens;
      bit locks;
      opens = ({d0, d1} == model_code);
      locks = 1'b0;
      push(S_IDLE, 0, 1'b0, 4'h0, 4'h0);
      push(S_ENTER, 0, 1'b0, 4'h0, 4'h0);
      push(S_CHECK, 1, 1'b1, d0, d1);
      if (opens) begin
         model_fails = 0;
         if (prog) begin
`ifdef LOCK_PROGRAM_EN
            push(S_OPEN, 1, 1'b0, 4'h0, 4'h0);
            push(S_PROG, 0, 1'b1, p0, p1);
            model_code = {p0, p1};
`else
            push(S_OPEN, OPEN_CYCLES, 1'b1, d0, d1);
`endif
         end else begin
            push(S_OPEN, OPEN_CYCLES, 1'b1, d0, d1);
         end
      end else begin
         model_fails++;
         push(S_FAIL, 1, 1'b1, d0, d1);
         if (model_fails >= MAX_FAILS) begin
            locks = 1'b1;
            model_fails = 0;
            push(S_LOCK, LOCK_CYCLES, 1'b1, d0, d1);
         end
      end
      press(d0, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      press(d1, 1, 1);
      if (opens && prog) begin
         program_req = 1'b1;
         tick();
         program_req = 1'b0;
         press(p0, 1, 1);
         press(p1, 1, 1);
      end else if (opens || locks) begin
         // These strobes land in OPEN / FAIL / LOCKOUT and must be dropped.
         press(4'($urandom), 1, 1);
         press(4'($urandom), 1, 1);
      end
      drain();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] a, b, pa, pb;
      model_code  = RESET_CODE;
      model_fails = 0;

      // Reset release with confirm held high.
      reset = 1'b0; confirm = 1'b1; digit = 4'h3;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("reset_state", 32'(state), 32'd0);
      check("reset_left", 32'(left), 32'd0);
      check("reset_right", 32'(right), 32'd0);
      check("reset_unlocked", 32'(unlocked), 32'd0);
      check("reset_alarm", 32'(alarm), 32'd0);
      repeat (3) tick();
      @(negedge clock);
      check("held_confirm_state", 32'(state), 32'd0);
      check("held_confirm_right", 32'(right), 32'd0);
      tick();
      confirm = 1'b0;
      tick();
      mon_en = 1'b1;
      tick();

      attempt(4'hF, 4'hA, 1'b0, 4'h0, 4'h0);
      repeat (3) attempt(4'hF, 4'hB, 1'b0, 4'h0, 4'h0);
      attempt(4'hF, 4'hA, 1'b0, 4'h0, 4'h0);

      // Reset in the middle of an entry.
      mon_en = 1'b0;
      tick();
      press(4'hF, 1, 1);
      @(negedge clock);
      check("mid_entry_state", 32'(state), 32'(S_ENTER));
      check("mid_entry_right", 32'(right), 32'hF);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("mid_reset_state", 32'(state), 32'd0);
      check("mid_reset_left", 32'(left), 32'd0);
      check("mid_reset_right", 32'(right), 32'd0);
      model_fails = 0;
      model_code  = RESET_CODE;
      tick();
      mon_en = 1'b1;
      tick();
      attempt(4'hF, 4'hA, 1'b0, 4'h0, 4'h0);

      // Code change request, then old and new codes.
      attempt(4'hF, 4'hA, 1'b1, 4'h0, 4'h6);
      attempt(4'hF, 4'hA, 1'b0, 4'h0, 4'h0);
      attempt(4'h0, 4'h6, 1'b0, 4'h0, 4'h0);

      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            a = model_code[7:4]; b = model_code[3:0];
         end else begin
            a = 4'($urandom); b = 4'($urandom);
         end
         pa = 4'($urandom); pb = 4'($urandom);
         attempt(a, b, ($urandom_range(0, 3) == 0), pa, pb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Sequencing controller for the 4-bit code-entry lock datapath. It collects keypad digits on `confirm` pulses, compares them against a stored code, and drives the `state`, `left` and `right` status/display outputs. It opens the lock for a bounded time and escalates repeated failures into a timed lockout with alarm. It sits between the keypad/switch inputs and the lock actuator and display drivers at the top of the lab system.

## Interface
- `CODE_LEN`, 2: digits per code (1..4).
- `RESET_CODE`, 8'hFA: code after reset (`4*CODE_LEN` bits, first digit in MS nibble).
- `MAX_FAILS`, 3: consecutive failures that trigger lockout (≥1).
- `OPEN_CYCLES`, 8: cycles spent in OPEN.
- `LOCK_CYCLES`, 16: cycles spent in LOCKOUT.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `confirm` in 1: digit strobe, level; a digit is accepted on its rising edge.
- `in` in 4: digit value, sampled with the `confirm` rising edge.
- `program` in 1: request a code change while open.
- `state` out 3: current FSM state encoding.
- `left` out 4: previously accepted digit.
- `right` out 4: most recently accepted digit.
- `unlocked` out 1: lock actuator enable.
- `alarm` out 1: lockout indicator.

## Operation
- States and encodings: IDLE=0, ENTER=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5, PROGRAM=6. Encoding 7 is unused and recovers to IDLE.
- Accept condition: `confirm`=1 while the registered previous `confirm` was 0. Only IDLE, ENTER and PROGRAM accept digits. Edges seen in any other state are dropped, not queued.
- On each accepted digit: `left`←`right`, `right`←`in`, the digit shifts into the entry buffer, and the digit count increments.
- IDLE: an accepted digit moves to ENTER. If `CODE_LEN`=1, it moves directly to CHECK.
- ENTER: the `CODE_LEN`-th accepted digit moves to CHECK.
- CHECK: lasts exactly 1 cycle. If buffer==code, go to OPEN and clear the fail counter. Otherwise go to FAIL.
- FAIL: lasts exactly 1 cycle. The fail counter increments. If it reaches `MAX_FAILS`, go to LOCKOUT. Otherwise go to IDLE.
- OPEN: `unlocked`=1 for exactly `OPEN_CYCLES` cycles, then IDLE.
- LOCKOUT: `alarm`=1 for exactly `LOCK_CYCLES` cycles. Then go to IDLE and clear the fail counter.
- Every entry into IDLE clears the digit count and entry buffer. `left`/`right` hold their values.
- `unlocked` and `alarm` are Moore decodes of the registered state.

## Timing
- Reset values: `state`=0, `left`=0, `right`=0, `unlocked`=0, `alarm`=0. Also fail counter=0, code=`RESET_CODE`, timer=0.
- The previous-`confirm` register resets to 1. A `confirm` held high through reset release therefore accepts no digit.
- Reset asserted in any state, including mid-entry, OPEN or LOCKOUT, takes effect on the next edge. Any partial entry is discarded.
- Latency:
  - Edge E accepts the last digit; `state`=CHECK after E.
  - `state`=OPEN or FAIL after E+1.
  - `unlocked` rises after E+1.
- OPEN and LOCKOUT durations are counted from the entering edge. `state` leaves on the N-th edge after entry.
- The fail counter saturates at `MAX_FAILS`. It never wraps.
- Simultaneous `program` and timer expiry in OPEN: `program` wins.

## Configuration
- `LOCK_PROGRAM_EN` defined:
  - In OPEN, `program`=1 moves the FSM to PROGRAM on the next edge and abandons the open timer.
  - PROGRAM keeps `unlocked`=1 and accepts `CODE_LEN` digits.
  - The last digit loads the code register, and the FSM moves to IDLE.
- `LOCK_PROGRAM_EN` undefined:
  - `program` is ignored and the PROGRAM state is not compiled.
  - The code register is the constant `RESET_CODE`.
  - The `program` port remains present.

## Structure
- Shared package `lock_pkg`:
  - state encodings;
  - digit width constant (4);
  - state width constant (3).
- Sub-module `lock_timer`: a loadable down-counter sized for max(`OPEN_CYCLES`, `LOCK_CYCLES`) with a terminal-count output. It is shared by OPEN and LOCKOUT.

## Test plan
- **Reset release:** hold `reset`=0 for 2 edges with `confirm`=1, then release. Required: all outputs 0, and no digit accepted until `confirm` falls and rises again.
- **Correct code:** pulse F then A. Required:
  - `state` goes 1, then 2, then 3 on consecutive relevant edges;
  - `left`=F, `right`=A;
  - `unlocked`=1 for exactly 8 cycles, then `state`=0.
- **Lockout:** enter F,B three times. Required:
  - FAIL after each CHECK;
  - the third FAIL leads to `state`=5 and `alarm`=1 for exactly 16 cycles;
  - `confirm` pulses during lockout are ignored;
  - `state`=0 afterwards, and F,A then opens immediately.
- **Reset mid-entry:** drive `reset`=0 after digit F. Required: `state`=0 and `left`=`right`=0; a following F,A opens.
- **Code change (`LOCK_PROGRAM_EN` defined):** open, assert `program`=1, enter 0,6. Required: `state`=6, then 0; F,A now fails; 0,6 opens.
- **Code change (macro undefined):** the same stimulus stays in OPEN for 8 cycles, and the code is unchanged.
